// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port synchronous data RAM (1-cycle read latency) between
//   the core MEM stage and a DMA/debug port. Arbitrates, sequences RAM cycles,
//   performs read-modify-write for partial stores and returns load data.
//
//   Ports:
//     clk_i, rst_i               clock, asynchronous active-high reset
//     core_req_i/we/be/addr/wdata  core request, held until core_ack_o
//     core_ack_o, core_rdata_o   1-cycle completion pulse, read word (valid on ack)
//     dma_*                      identical set for the DMA/debug requester
//     ram_en_o, ram_we_o         RAM enable / write strobe (registered)
//     ram_addr_o, ram_wdata_o    word-aligned address, write word (registered)
//     ram_rdata_i                RAM read data, valid the cycle after a read
//     busy_o                     high whenever the FSM is not IDLE
//
//   Build option: define ARB_RR_EN for round-robin arbitration on ties;
//   otherwise the core has fixed priority over the DMA port.
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    core_req_i,
  input  logic                    core_we_i,
  input  logic [DATA_WIDTH/8-1:0] core_be_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  output logic                    core_ack_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  input  logic                    dma_req_i,
  input  logic                    dma_we_i,
  input  logic [DATA_WIDTH/8-1:0] dma_be_i,
  input  logic [ADDR_WIDTH-1:0]   dma_addr_i,
  input  logic [DATA_WIDTH-1:0]   dma_wdata_i,
  output logic                    dma_ack_o,
  output logic [DATA_WIDTH-1:0]   dma_rdata_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RESP,
    S_MERGE,
    S_WR
  } state_t;

  state_t                  state_q, state_d;
  logic                    gnt_dma_q, gnt_dma_d;   // port owning the current transaction
  logic                    last_dma_q, last_dma_d; // port granted on the last accept
  logic                    we_q, we_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ram_en_q, ram_en_d;
  logic                    ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    core_ack_q, core_ack_d;
  logic                    dma_ack_q, dma_ack_d;
  logic                    ack_d;

  logic                    pick_dma;
  logic                    sel_we;
  logic [BE_W-1:0]         sel_be;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Byte offset never reaches the RAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{core_addr_i[1:0], dma_addr_i[1:0]};

`ifdef ARB_RR_EN
  // On a tie, grant the port that did not win the previous accept.
  assign pick_dma = dma_req_i & (~core_req_i | ~last_dma_q);
`else
  assign pick_dma = dma_req_i & ~core_req_i;
`endif

  assign sel_we    = pick_dma ? dma_we_i    : core_we_i;
  assign sel_be    = pick_dma ? dma_be_i    : core_be_i;
  assign sel_addr  = pick_dma ? dma_addr_i  : core_addr_i;
  assign sel_wdata = pick_dma ? dma_wdata_i : core_wdata_i;

  // Registered outputs are computed for the state being entered, so they are
  // visible during that state.
  always_comb begin
    state_d     = state_q;
    gnt_dma_d   = gnt_dma_q;
    last_dma_d  = last_dma_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ack_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (core_req_i || dma_req_i) begin
          gnt_dma_d  = pick_dma;
          last_dma_d = pick_dma;
          we_d       = sel_we;
          be_d       = sel_be;
          wdata_d    = sel_wdata;
          ram_addr_d = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
          if (sel_we && (sel_be == '1)) begin
            state_d     = S_WR;
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_wdata_d = sel_wdata;
            ack_d       = 1'b1;
          end else if (sel_we && (sel_be == '0)) begin
            // Empty write: acknowledge without touching the RAM.
            state_d = S_WR;
            ack_d   = 1'b1;
          end else begin
            state_d  = S_RD;
            ram_en_d = 1'b1;
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d = S_MERGE;
        end else begin
          state_d = S_RESP;
          ack_d   = 1'b1;
        end
      end
      S_MERGE: begin
        state_d  = S_WR;
        ram_en_d = 1'b1;
        ram_we_d = 1'b1;
        ack_d    = 1'b1;
        for (int unsigned i = 0; i < BE_W; i++) begin
          ram_wdata_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_rdata_i[8*i +: 8];
        end
      end
      S_RESP, S_WR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    core_ack_d = ack_d & ~gnt_dma_d;
    dma_ack_d  = ack_d &  gnt_dma_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      gnt_dma_q   <= 1'b0;
      last_dma_q  <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      core_ack_q  <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_dma_q   <= gnt_dma_d;
      last_dma_q  <= last_dma_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      core_ack_q  <= core_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign core_ack_o   = core_ack_q;
  assign dma_ack_o    = dma_ack_q;
  assign busy_o       = (state_q != S_IDLE);
  assign core_rdata_o = ((state_q == S_RESP) && !gnt_dma_q) ? ram_rdata_i : '0;
  assign dma_rdata_o  = ((state_q == S_RESP) &&  gnt_dma_q) ? ram_rdata_i : '0;

endmodule
